// File: rtl/demux_dispatch_fifo.sv
// demux_dispatch_fifo
// Buffers {data, select} routing requests in a small FIFO and presents each
// one on registered demux inputs for HOLD_CYCLES cycles, strictly in order.
// A two-state FSM (IDLE/HOLD) pops the head and chains requests back to back.

module demux_dispatch_fifo #(
    parameter int DEPTH       = 4,
    parameter int SEL_W       = 3,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_data,
    input  logic [SEL_W-1:0]           in_sel,
    input  logic                       clear,
    output logic                       dmx_i,
    output logic [SEL_W-1:0]           dmx_s,
    output logic                       dmx_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int HC_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int ENT_W = SEL_W + 1;

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [HC_W-1:0]  r_hold_cnt;
    logic             r_dmx_i;
    logic [SEL_W-1:0] r_dmx_s;
    logic             r_dmx_valid;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [ENT_W-1:0] w_head;
    logic [HC_W-1:0]  w_hold_nxt;
    logic             w_dmx_i_nxt;
    logic [SEL_W-1:0] w_dmx_s_nxt;
    logic             w_valid_nxt;

    // Ready depends only on registered occupancy and clear, never on a pop.
    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign in_ready = !w_full && !clear;
    assign w_push   = in_valid && in_ready;
    assign w_head   = r_mem[r_rd_ptr];

    assign dmx_i     = r_dmx_i;
    assign dmx_s     = r_dmx_s;
    assign dmx_valid = r_dmx_valid;
    assign count     = r_count;
    assign busy      = r_dmx_valid || !w_empty;

    // Storage array; only written on an accepted push, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_data, in_sel};
        end
    end

    // Pointer and occupancy bookkeeping; clear flushes everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Next-state logic: pop when idle or when the current hold has expired.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_hold_nxt  = r_hold_cnt;
        w_dmx_i_nxt = r_dmx_i;
        w_dmx_s_nxt = r_dmx_s;
        w_valid_nxt = r_dmx_valid;

        if (clear) begin
            w_state_nxt = S_IDLE;
            w_hold_nxt  = '0;
            w_dmx_i_nxt = 1'b0;
            w_dmx_s_nxt = '0;
            w_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_HOLD;
                        w_dmx_i_nxt = w_head[SEL_W];
                        w_dmx_s_nxt = w_head[SEL_W-1:0];
                        w_valid_nxt = 1'b1;
                        w_hold_nxt  = HC_W'(HOLD_CYCLES - 1);
                    end
                end
                S_HOLD: begin
                    if (r_hold_cnt != '0) begin
                        w_hold_nxt = r_hold_cnt - HC_W'(1);
                    end else if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_dmx_i_nxt = w_head[SEL_W];
                        w_dmx_s_nxt = w_head[SEL_W-1:0];
                        w_valid_nxt = 1'b1;
                        w_hold_nxt  = HC_W'(HOLD_CYCLES - 1);
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_dmx_i_nxt = 1'b0;
                        w_valid_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_valid_nxt = 1'b0;
                    w_dmx_i_nxt = 1'b0;
                end
            endcase
        end
    end

    // State, hold counter and registered demux outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_hold_cnt  <= '0;
            r_dmx_i     <= 1'b0;
            r_dmx_s     <= '0;
            r_dmx_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_dmx_i     <= w_dmx_i_nxt;
            r_dmx_s     <= w_dmx_s_nxt;
            r_dmx_valid <= w_valid_nxt;
        end
    end

endmodule

// File: tb/tb_demux_dispatch_fifo.sv
// Directed testbench for demux_dispatch_fifo.
// Main instance uses HOLD_CYCLES=2; a second instance uses HOLD_CYCLES=1
// for the continuous-stream scenario.

module tb_demux_dispatch_fifo;

    logic       clk;
    logic       rst_n;
    logic       inValid;
    logic       inReady;
    logic       inData;
    logic [2:0] inSel;
    logic       clear;
    logic       dmxI;
    logic [2:0] dmxS;
    logic       dmxValid;
    logic [2:0] count;
    logic       busy;

    logic       inValid1;
    logic       inReady1;
    logic       inData1;
    logic [2:0] inSel1;
    logic       clear1;
    logic       dmxI1;
    logic [2:0] dmxS1;
    logic       dmxValid1;
    logic [2:0] count1;
    logic       busy1;

    int assertions = 0;
    int failures   = 0;

    demux_dispatch_fifo #(.DEPTH(4), .SEL_W(3), .HOLD_CYCLES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady),
        .in_data(inData), .in_sel(inSel), .clear(clear), .dmx_i(dmxI),
        .dmx_s(dmxS), .dmx_valid(dmxValid), .count(count), .busy(busy)
    );

    demux_dispatch_fifo #(.DEPTH(4), .SEL_W(3), .HOLD_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid1), .in_ready(inReady1),
        .in_data(inData1), .in_sel(inSel1), .clear(clear1), .dmx_i(dmxI1),
        .dmx_s(dmxS1), .dmx_valid(dmxValid1), .count(count1), .busy(busy1)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        #12;
        assertions++;
        if (dmxValid !== 1'b0 || dmxI !== 1'b0 || dmxS !== 3'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got v=%b i=%b s=%0d, expected v=0 i=0 s=0", dmxValid, dmxI, dmxS);
        end
        assertions++;
        if (count !== 3'd0 || busy !== 1'b0 || inReady !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_status: got count=%0d busy=%b ready=%b, expected 0 0 1", count, busy, inReady);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_push();
        $display("[TB] test_single_push");
        inValid = 1'b1; inSel = 3'd5; inData = 1'b1;
        step();
        inValid = 1'b0;
        assertions++;
        if (count !== 3'd1 || dmxValid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_accept: got count=%0d v=%b busy=%b, expected 1 0 1", count, dmxValid, busy);
        end
        for (int c = 0; c < 2; c++) begin
            step();
            assertions++;
            if (dmxValid !== 1'b1 || dmxS !== 3'd5 || dmxI !== 1'b1) begin
                failures++;
                $display("[TB] FAIL single_hold%0d: got v=%b s=%0d i=%b, expected 1 5 1", c, dmxValid, dmxS, dmxI);
            end
        end
        step();
        assertions++;
        if (dmxValid !== 1'b0 || dmxI !== 1'b0 || dmxS !== 3'd5 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_release: got v=%b i=%b s=%0d busy=%b, expected 0 0 5 0", dmxValid, dmxI, dmxS, busy);
        end
    endtask

    task automatic test_stream_full();
        bit sawStall;
        $display("[TB] test_stream_full");
        sawStall = 1'b0;
        fork
            begin
                for (int n = 0; n < 8; n++) begin
                    bit acc;
                    int tries;
                    tries = 0;
                    do begin
                        inValid = 1'b1; inSel = 3'(n); inData = n[0];
                        #1;
                        acc = inReady;
                        if (!acc) sawStall = 1'b1;
                        assertions++;
                        if (inReady !== (count != 3'd4)) begin
                            failures++;
                            $display("[TB] FAIL stream_ready: got ready=%b at count=%0d, expected %b", inReady, count, count != 3'd4);
                        end
                        step();
                        tries++;
                    end while (!acc && tries < 40);
                    if (!acc) begin
                        failures++;
                        $display("[TB] FAIL stream_stall_bound: got no accept for item %0d, expected accept", n);
                    end
                end
                inValid = 1'b0;
            end
            begin
                bit found;
                found = 1'b0;
                for (int w = 0; w < 20 && !found; w++) begin
                    step();
                    if (dmxValid) found = 1'b1;
                end
                assertions++;
                if (!found) begin
                    failures++;
                    $display("[TB] FAIL stream_start: got no dmx_valid, expected within 20 cycles");
                end
                for (int k = 0; k < 16; k++) begin
                    int e;
                    logic [7:0] yAct;
                    logic [7:0] yExp;
                    if (k > 0) step();
                    e = k / 2;
                    yAct = 8'(dmxI) << dmxS;
                    yExp = 8'(e[0]) << e;
                    assertions++;
                    if (dmxValid !== 1'b1 || dmxS !== 3'(e) || dmxI !== e[0] || yAct !== yExp) begin
                        failures++;
                        $display("[TB] FAIL stream_cycle%0d: got v=%b s=%0d i=%b y=%h, expected 1 %0d %b %h", k, dmxValid, dmxS, dmxI, yAct, e, e[0], yExp);
                    end
                end
                step();
                assertions++;
                if (dmxValid !== 1'b0 || busy !== 1'b0 || count !== 3'd0) begin
                    failures++;
                    $display("[TB] FAIL stream_end: got v=%b busy=%b count=%0d, expected 0 0 0", dmxValid, busy, count);
                end
            end
        join
        assertions++;
        if (sawStall !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stream_backpressure: got stall=%b, expected 1", sawStall);
        end
    endtask

    task automatic test_clear();
        $display("[TB] test_clear");
        inValid = 1'b1; inSel = 3'd1; inData = 1'b1;
        step();
        inSel = 3'd2; inData = 1'b0;
        step();
        inSel = 3'd3; inData = 1'b1;
        step();
        assertions++;
        if (dmxValid !== 1'b1 || dmxS !== 3'd1 || dmxI !== 1'b1 || count !== 3'd2) begin
            failures++;
            $display("[TB] FAIL clear_pre: got v=%b s=%0d i=%b count=%0d, expected 1 1 1 2", dmxValid, dmxS, dmxI, count);
        end
        clear = 1'b1; inSel = 3'd4; inData = 1'b1;
        #1;
        assertions++;
        if (inReady !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clear_ready: got ready=%b, expected 0", inReady);
        end
        step();
        clear = 1'b0; inValid = 1'b0;
        assertions++;
        if (dmxValid !== 1'b0 || dmxI !== 1'b0 || dmxS !== 3'd0 || count !== 3'd0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clear_flush: got v=%b i=%b s=%0d count=%0d busy=%b, expected 0 0 0 0 0", dmxValid, dmxI, dmxS, count, busy);
        end
        for (int c = 0; c < 6; c++) begin
            step();
            assertions++;
            if (dmxValid !== 1'b0 || count !== 3'd0) begin
                failures++;
                $display("[TB] FAIL clear_quiet%0d: got v=%b count=%0d, expected 0 0", c, dmxValid, count);
            end
        end
    endtask

    task automatic test_full_pop();
        $display("[TB] test_full_pop");
        for (int n = 1; n <= 7; n++) begin
            inValid = 1'b1; inSel = 3'(n); inData = n[0];
            step();
        end
        inSel = 3'd0; inData = 1'b1;
        #1;
        assertions++;
        if (count !== 3'd4 || dmxS !== 3'd3 || inReady !== 1'b0) begin
            failures++;
            $display("[TB] FAIL full_before_pop: got count=%0d s=%0d ready=%b, expected 4 3 0", count, dmxS, inReady);
        end
        step();
        inValid = 1'b0;
        assertions++;
        if (count !== 3'd3 || dmxS !== 3'd4 || inReady !== 1'b1) begin
            failures++;
            $display("[TB] FAIL full_after_pop: got count=%0d s=%0d ready=%b, expected 3 4 1", count, dmxS, inReady);
        end
        for (int c = 0; c < 8; c++) step();
        assertions++;
        if (dmxValid !== 1'b0 || count !== 3'd0 || dmxS !== 3'd7) begin
            failures++;
            $display("[TB] FAIL full_drain: got v=%b count=%0d s=%0d, expected 0 0 7", dmxValid, count, dmxS);
        end
    endtask

    task automatic test_async_reset();
        $display("[TB] test_async_reset");
        inValid = 1'b1; inSel = 3'd6; inData = 1'b1;
        step();
        inSel = 3'd3; inData = 1'b0;
        step();
        inValid = 1'b0;
        assertions++;
        if (dmxValid !== 1'b1 || dmxS !== 3'd6 || count !== 3'd1) begin
            failures++;
            $display("[TB] FAIL areset_pre: got v=%b s=%0d count=%0d, expected 1 6 1", dmxValid, dmxS, count);
        end
        #3;
        rst_n = 1'b0;
        #1;
        assertions++;
        if (dmxValid !== 1'b0 || dmxI !== 1'b0 || dmxS !== 3'd0 || count !== 3'd0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL areset_drop: got v=%b i=%b s=%0d count=%0d busy=%b, expected 0 0 0 0 0", dmxValid, dmxI, dmxS, count, busy);
        end
        #2;
        rst_n = 1'b1;
        step();
        inValid = 1'b1; inSel = 3'd2; inData = 1'b0;
        step();
        inValid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            assertions++;
            if (dmxValid !== 1'b1 || dmxS !== 3'd2 || dmxI !== 1'b0) begin
                failures++;
                $display("[TB] FAIL areset_new%0d: got v=%b s=%0d i=%b, expected 1 2 0", c, dmxValid, dmxS, dmxI);
            end
        end
        step();
        assertions++;
        if (dmxValid !== 1'b0 || count !== 3'd0 || dmxS !== 3'd2) begin
            failures++;
            $display("[TB] FAIL areset_end: got v=%b count=%0d s=%0d, expected 0 0 2", dmxValid, count, dmxS);
        end
    endtask

    task automatic test_back_to_back();
        $display("[TB] test_back_to_back");
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) begin
                inValid1 = 1'b1; inSel1 = 3'(k); inData1 = k[1];
                #1;
                assertions++;
                if (inReady1 !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL b2b_ready%0d: got ready=%b, expected 1", k, inReady1);
                end
            end else begin
                inValid1 = 1'b0;
            end
            step();
            if (k == 0) begin
                assertions++;
                if (dmxValid1 !== 1'b0 || count1 !== 3'd1) begin
                    failures++;
                    $display("[TB] FAIL b2b_first: got v=%b count=%0d, expected 0 1", dmxValid1, count1);
                end
            end else begin
                int j;
                int expCount;
                j = k - 1;
                expCount = (k < 8) ? 1 : 0;
                assertions++;
                if (dmxValid1 !== 1'b1 || dmxS1 !== 3'(j) || dmxI1 !== j[1] || count1 !== 3'(expCount)) begin
                    failures++;
                    $display("[TB] FAIL b2b_cycle%0d: got v=%b s=%0d i=%b count=%0d, expected 1 %0d %b %0d", k, dmxValid1, dmxS1, dmxI1, count1, j, j[1], expCount);
                end
            end
        end
        step();
        assertions++;
        if (dmxValid1 !== 1'b0 || dmxS1 !== 3'd7 || busy1 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_end: got v=%b s=%0d busy=%b, expected 0 7 0", dmxValid1, dmxS1, busy1);
        end
    endtask

    // Scenario sequencer.
    initial begin
        rst_n = 1'b0;
        inValid = 1'b0; inData = 1'b0; inSel = 3'd0; clear = 1'b0;
        inValid1 = 1'b0; inData1 = 1'b0; inSel1 = 3'd0; clear1 = 1'b0;
        test_reset();
        test_single_push();
        test_stream_full();
        test_clear();
        test_full_pop();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/demux_dispatch_fifo.md
Name: demux_dispatch_fifo

Overview:
Upstream feeder for the 1-to-8 demultiplexer. Accepts routing requests (one data bit plus a 3-bit destination select) over a valid/ready handshake and buffers them in a small FIFO. Presents each request on registered demux inputs (dmx_i, dmx_s) for a fixed number of cycles, strictly in arrival order. dmx_valid tells the demux and its checkers when the presented pair is meaningful.

Parameters:
DEPTH, 4, FIFO entries; power of 2, >=2
SEL_W, 3, select width; demux has 2**SEL_W outputs
HOLD_CYCLES, 2, cycles each request is held on dmx_i/dmx_s; >=1

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request present
in_ready  output  1  FIFO can accept; equals !full && !clear (combinational)
in_data  input  1  data bit to route
in_sel  input  SEL_W  destination channel
clear  input  1  synchronous flush
dmx_i  output  1  registered data to demux i
dmx_s  output  SEL_W  registered select to demux s
dmx_valid  output  1  dmx_i/dmx_s carry a live request
count  output  $clog2(DEPTH+1)  FIFO occupancy (excludes the request being held)
busy  output  1  dmx_valid || count!=0

Behaviour:
- Reset (rst_n=0, asynchronous): FIFO empty, count=0, pointers=0, FSM=IDLE, hold counter=0, dmx_valid=0, dmx_i=0, dmx_s=0, busy=0. in_ready=1 once clear=0. Reset mid-hold abandons the request immediately; nothing is retained.
- Push: on an edge where in_valid && in_ready, {in_data,in_sel} is written at wr_ptr, wr_ptr wraps modulo DEPTH, and count increments. in_valid while !in_ready is stalled, not dropped.
- Full: in_ready=0 when count==DEPTH, even if a pop occurs that cycle. No combinational ready-from-pop path.
- FSM states IDLE and HOLD:
  - IDLE: if count!=0, pop head on the edge. dmx_i/dmx_s take the head, dmx_valid=1, hold_cnt=HOLD_CYCLES-1, go to HOLD. Otherwise stay.
  - HOLD with hold_cnt>0: decrement; outputs stable.
  - HOLD with hold_cnt==0 and count!=0: pop the next entry on the same edge. Back-to-back, no gap cycle, dmx_valid stays 1.
  - HOLD with hold_cnt==0 and count==0: go to IDLE. dmx_valid=0, dmx_i=0, dmx_s retains its last value.
- Latency: a request accepted on edge N appears on the outputs after edge N+1 if the FSM is idle. No bypass path.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- Ordering: strict FIFO; every accepted request is presented exactly once, for exactly HOLD_CYCLES cycles.
- clear=1 on an edge: FIFO emptied (pointers=0, count=0), FSM=IDLE, dmx_valid=0, dmx_i=0, dmx_s=0. A push in the same cycle is blocked because in_ready=0. clear has priority over push, pop and hold.
- Contract with the demux: while dmx_valid=1, the demux output must equal dmx_i << dmx_s.

Test Plan:
1. Reset, then single push sel=5 data=1 (HOLD=2) -> dmx_valid=1, dmx_s=5, dmx_i=1 for exactly 2 cycles starting one cycle after the accept edge; then dmx_valid=0, dmx_i=0, dmx_s=5, busy=0.
2. in_valid held high for 8 pushes (sel 0..7, data=sel[0]) -> in_ready drops when count reaches 4; outputs show sel 0..7 in order, 2 cycles each, 16 contiguous dmx_valid cycles; demux y==dmx_i<<dmx_s every valid cycle.
3. Push 3 requests, assert clear during the first request's hold -> next cycle dmx_valid=0, dmx_i=0, dmx_s=0, count=0; push attempted in the clear cycle is not accepted; no later output.
4. Full FIFO plus a pop edge with in_valid=1 -> in_ready=0 that cycle, push refused, count goes 4->3, in_ready=1 next cycle.
5. Assert rst_n=0 mid-hold, asynchronously between edges -> dmx_valid, dmx_i, dmx_s, count drop to 0 without waiting for a clock; after release, a new push is presented normally.
6. HOLD_CYCLES=1 with a continuous stream -> a new request every cycle and no gaps; interleaving push and pop each cycle keeps count constant.
